trivium_ctrl: RTL and testbench
===============================

# trivium_ctrl

Sequencing controller for the Trivium keystream core. It accepts a key/IV pair and loads it into the core, then runs the mandatory 1152-round warm-up. It then meters keystream out one bit per accepted plaintext bit, producing ciphertext over a valid/ready stream. It sits between the host key interface and the data path, and it is the only block that drives the core's load/step controls.

## Interface
- `INIT_ROUNDS`, 1152, warm-up rounds run after each load.
- `CNT_W`, 64, width of the keystream bit counter.
- `MAX_BITS`, 2^CNT_W−1, bits encrypted per key before a rekey is forced.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `key`  in  80  key, sampled on accepted `start`.
- `iv`  in  80  initialisation vector, sampled on accepted `start`.
- `start`  in  1  request to (re)key; single-cycle pulse.
- `din_valid`  in  1  plaintext bit valid.
- `din`  in  1  plaintext bit.
- `din_ready`  out  1  controller accepts `din` this cycle.
- `dout_valid`  out  1  ciphertext bit valid.
- `dout`  out  1  ciphertext bit.
- `dout_ready`  in  1  downstream accepts `dout`.
- `core_load`  out  1  core loads `core_key`/`core_iv` into its state.
- `core_key`  out  80  registered key to core.
- `core_iv`  out  80  registered IV to core.
- `core_step`  out  1  advance core one round this cycle.
- `core_z`  in  1  core keystream bit for its current state (combinational).
- `busy`  out  1  state is LOAD or WARMUP.
- `ready`  out  1  state is RUN.
- `rekey_req`  out  1  state is EXHAUSTED.
- `err`  out  1  sticky; last `start` was rejected.

## Operation
- States: IDLE, LOAD, WARMUP, RUN, EXHAUSTED.
- Accepted start is `start`=1 with `key`≠0, in any state.
  - Next state is LOAD.
  - `core_key`/`core_iv` capture `key`/`iv`.
  - `err` clears; round counter and bit counter clear; `dout_valid` clears (pending bit is dropped).
- Rejected start is `start`=1 with `key`=0.
  - `err` is set; state and all other registers are unchanged.
- LOAD: lasts one cycle; `core_load`=1; then goes to WARMUP.
- WARMUP: `core_step`=1 every cycle.
  - Round counter counts from 0 to INIT_ROUNDS−1; on its last value the next state is RUN.
- RUN:
  - `din_ready` = !`start` && (!`dout_valid` || `dout_ready`).
  - On accept (`din_valid`&&`din_ready`): `dout` ← `din`^`core_z`, `dout_valid` ← 1, `core_step`=1 for the same cycle, bit counter +1.
  - If the accept brings the counter to MAX_BITS, the next state is EXHAUSTED.
- EXHAUSTED: `din_ready`=0; a pending `dout` still drains; only an accepted start leaves this state.
- `dout_valid` clears on `dout_ready` when no new accept happens in the same cycle.
- `core_step` is never asserted outside WARMUP and RUN-accept; `core_load` and `core_step` are never high together.
- `start` has priority over a same-cycle data accept.

## Timing
- Reset values: state IDLE; all outputs 0, including `core_key`/`core_iv`.
- Reset mid-operation aborts immediately; a new accepted start repeats the full warm-up.
- Start latency:
  - Cycle 0: accepted start.
  - Cycle 1: LOAD.
  - Cycles 2–1153: WARMUP, 1152 cycles of `core_step`.
  - Cycle 1154: `ready`=1 and `din_ready` may assert.
- Data latency is 1 cycle from accept to `dout_valid`. Sustained throughput is 1 bit per cycle with `dout_ready` held at 1.
- Decoding: state flags, `core_load` and warm-up `core_step` decode from state; RUN `core_step` and `din_ready` are combinational.
- Round counter width is $clog2(INIT_ROUNDS); bit counter is CNT_W bits and never wraps.

## Structure
- `trivium_pkg` holds:
  - the state enum `trivium_ctrl_state_t`;
  - `TRIVIUM_KEY_W`=80 and `TRIVIUM_IV_W`=80;
  - `TRIVIUM_INIT_ROUNDS`=1152.
- The `trivium_core` datapath is instantiated beside this block, at the parent level, not inside it.
- One sub-module is natural: `trivium_out_reg`, the single-entry valid/ready output register holding `dout`/`dout_valid`.

## Test plan
- Reset: with `rst`=0, every output is 0; after release with no stimulus, `din_ready` stays 0 and state stays IDLE.
- Rejected start: `start` with `key`=0 → `err`=1 next cycle; `core_load` never asserts; state stays IDLE. A following start with `key`=80'h1 → `err`=0.
- Start with `key`=80'h0123…, `iv`=80'hABCD… →
  - `core_load` high exactly at cycle 1;
  - `core_step` high exactly cycles 2–1153;
  - `ready`=1 at cycle 1154;
  - `core_key`/`core_iv` match the sampled values.
- RUN with a `core_z` model of 1,0,1,1 and `din` of 1,1,0,0 → `dout` is 0,1,1,1.
  - With `dout_ready`=0 for 3 cycles: `din_ready`=0, `dout` is held, `core_step`=0.
- `MAX_BITS`=8: after the 8th accept, `rekey_req`=1 and `din_ready`=0; the last bit still drains. A new start → LOAD, `rekey_req`=0.
- Reset asserted at warm-up cycle 500 → outputs 0 asynchronously. After a restart, `core_step` asserts for a full 1152 cycles.
- Start in RUN with `din_valid`=1 and `dout_valid`=1 → no accept; `dout_valid` cleared; LOAD next cycle.

Source files
------------

// File: rtl/trivium_pkg.sv
//------------------------------------------------------------------------------
// trivium_pkg : shared types and sizes for the Trivium sequencing controller
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package trivium_pkg;

    localparam int unsigned TRIVIUM_KEY_W       = 80;
    localparam int unsigned TRIVIUM_IV_W        = 80;
    localparam int unsigned TRIVIUM_INIT_ROUNDS = 1152;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WARMUP    = 3'd2,
        ST_RUN       = 3'd3,
        ST_EXHAUSTED = 3'd4
    } trivium_ctrl_state_t;

    // An all-zero key is the only key the controller refuses.
    function automatic logic key_is_valid(input logic [TRIVIUM_KEY_W-1:0] key);
        return |key;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trivium_out_reg.sv
//------------------------------------------------------------------------------
// trivium_out_reg : single-entry valid/ready register for the ciphertext bit
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trivium_out_reg
    import trivium_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic load_i,
    input  logic data_i,
    input  logic dout_ready_i,
    output logic dout_o,
    output logic dout_valid_o
);

    logic dout_q, dout_d;
    logic valid_q, valid_d;

    // A flush (rekey) wins over a load; the pending bit is simply dropped.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            dout_d  = data_i;
            valid_d = 1'b1;
        end else if (dout_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/trivium_ctrl.sv
//------------------------------------------------------------------------------
// trivium_ctrl : key load, 1152-round warm-up and keystream metering for Trivium
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trivium_ctrl
    import trivium_pkg::*;
#(
    parameter int unsigned         INIT_ROUNDS = TRIVIUM_INIT_ROUNDS,
    parameter int unsigned         CNT_W       = 64,
    parameter logic [CNT_W-1:0]    MAX_BITS    = '1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [TRIVIUM_KEY_W-1:0] key_i,
    input  logic [TRIVIUM_IV_W-1:0]  iv_i,
    input  logic                     start_i,
    input  logic                     din_valid_i,
    input  logic                     din_i,
    output logic                     din_ready_o,
    output logic                     dout_valid_o,
    output logic                     dout_o,
    input  logic                     dout_ready_i,
    output logic                     core_load_o,
    output logic [TRIVIUM_KEY_W-1:0] core_key_o,
    output logic [TRIVIUM_IV_W-1:0]  core_iv_o,
    output logic                     core_step_o,
    input  logic                     core_z_i,
    output logic                     busy_o,
    output logic                     ready_o,
    output logic                     rekey_req_o,
    output logic                     err_o
);

    localparam int unsigned      RND_W    = (INIT_ROUNDS > 1) ? $clog2(INIT_ROUNDS) : 1;
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(INIT_ROUNDS - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = MAX_BITS - CNT_W'(1);

    trivium_ctrl_state_t state_q, state_d;

    logic [RND_W-1:0]         round_q, round_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [TRIVIUM_KEY_W-1:0] key_q, key_d;
    logic [TRIVIUM_IV_W-1:0]  iv_q, iv_d;
    logic                     err_q, err_d;

    logic start_ok;
    logic start_rej;
    logic accept;

    assign start_ok  = start_i &&  key_is_valid(key_i);
    assign start_rej = start_i && !key_is_valid(key_i);

    // A start in the same cycle blocks data so the rekey never races an accept.
    assign din_ready_o = (state_q == ST_RUN) && !start_i && (!dout_valid_o || dout_ready_i);
    assign accept      = din_valid_i && din_ready_o;

    assign core_load_o = (state_q == ST_LOAD);
    assign core_step_o = (state_q == ST_WARMUP) || accept;
    assign busy_o      = (state_q == ST_LOAD) || (state_q == ST_WARMUP);
    assign ready_o     = (state_q == ST_RUN);
    assign rekey_req_o = (state_q == ST_EXHAUSTED);
    assign err_o       = err_q;
    assign core_key_o  = key_q;
    assign core_iv_o   = iv_q;

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        bit_cnt_d = bit_cnt_q;
        key_d     = key_q;
        iv_d      = iv_q;
        err_d     = err_q;

        if (start_ok) begin
            state_d   = ST_LOAD;
            key_d     = key_i;
            iv_d      = iv_i;
            err_d     = 1'b0;
            round_d   = '0;
            bit_cnt_d = '0;
        end else begin
            if (start_rej) begin
                err_d = 1'b1;
            end
            case (state_q)
                ST_LOAD: begin
                    state_d = ST_WARMUP;
                    round_d = '0;
                end
                ST_WARMUP: begin
                    if (round_q == RND_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        round_d = round_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        // Saturate rather than wrap; EXHAUSTED stops traffic first anyway.
                        if (bit_cnt_q != '1) begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_EXHAUSTED;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            round_q   <= '0;
            bit_cnt_q <= '0;
            key_q     <= '0;
            iv_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            bit_cnt_q <= bit_cnt_d;
            key_q     <= key_d;
            iv_q      <= iv_d;
            err_q     <= err_d;
        end
    end

    trivium_out_reg u_out_reg (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (start_ok),
        .load_i       (accept),
        .data_i       (din_i ^ core_z_i),
        .dout_ready_i (dout_ready_i),
        .dout_o       (dout_o),
        .dout_valid_o (dout_valid_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_trivium_ctrl.sv
//------------------------------------------------------------------------------
// tb_trivium_ctrl : directed self-checking bench with a ciphertext scoreboard
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_trivium_ctrl;

    localparam logic [79:0] K_MAIN = 80'h0123_4567_89AB_CDEF_0123;
    localparam logic [79:0] V_MAIN = 80'hABCD_EF01_2345_6789_ABCD;
    localparam logic [79:0] K_ALT  = 80'hFEED_FACE_CAFE_BEEF_0042;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [79:0] key_i, iv_i;
    logic        start_i, din_valid_i, din_i, dout_ready_i, core_z_i;
    logic        din_ready_o, dout_valid_o, dout_o, core_load_o, core_step_o;
    logic [79:0] core_key_o, core_iv_o;
    logic        busy_o, ready_o, rekey_req_o, err_o;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    int steps, ncyc, loads;

    always #5 clk_i = ~clk_i;

    trivium_ctrl #(
        .INIT_ROUNDS (1152),
        .CNT_W       (64),
        .MAX_BITS    (64'd8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .key_i        (key_i),
        .iv_i         (iv_i),
        .start_i      (start_i),
        .din_valid_i  (din_valid_i),
        .din_i        (din_i),
        .din_ready_o  (din_ready_o),
        .dout_valid_o (dout_valid_o),
        .dout_o       (dout_o),
        .dout_ready_i (dout_ready_i),
        .core_load_o  (core_load_o),
        .core_key_o   (core_key_o),
        .core_iv_o    (core_iv_o),
        .core_step_o  (core_step_o),
        .core_z_i     (core_z_i),
        .busy_o       (busy_o),
        .ready_o      (ready_o),
        .rekey_req_o  (rekey_req_o),
        .err_o        (err_o)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard bookkeeping on settled pre-edge values, then advance one cycle.
    task automatic tick();
        bit e;
        if (dout_valid_o && dout_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow observed=dout_valid expected=no_output");
            end else begin
                e = exp_q.pop_front();
                chk1("sb_dout", dout_o, e);
            end
        end
        if (start_i && key_i != '0) begin
            exp_q.delete();
        end else if (din_valid_i && din_ready_o) begin
            exp_q.push_back(din_i ^ core_z_i);
        end
        @(posedge clk_i);
        #1;
    endtask

    // Runs from the LOAD cycle until ready, bounded by a cycle budget.
    task automatic warm(output int n_steps, output int n_cyc, output int n_loads);
        n_steps = 0;
        n_cyc   = 0;
        n_loads = 0;
        while (!ready_o && n_cyc < 2000) begin
            if (core_step_o) n_steps++;
            if (core_load_o) n_loads++;
            if (core_step_o && core_load_o) n_loads += 1000;
            tick();
            n_cyc++;
        end
    endtask

    initial begin
        bit dpat [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bit zpat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit d2   [3] = '{1'b0, 1'b1, 1'b0};
        bit z2   [3] = '{1'b1, 1'b1, 1'b0};

        rst_ni = 1'b0; key_i = '0; iv_i = '0; start_i = 1'b0;
        din_valid_i = 1'b0; din_i = 1'b0; dout_ready_i = 1'b0; core_z_i = 1'b0;
        #3;
        chkw("rst_flags", 80'({din_ready_o, dout_valid_o, dout_o, core_load_o, core_step_o,
                               busy_o, ready_o, rekey_req_o, err_o}), '0);
        chkw("rst_core_key", core_key_o, '0);
        chkw("rst_core_iv", core_iv_o, '0);

        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        dout_ready_i = 1'b1;
        repeat (3) tick();
        chk1("idle_din_ready", din_ready_o, 1'b0);
        chkw("idle_flags", 80'({busy_o, ready_o, rekey_req_o, err_o, core_load_o, core_step_o}), '0);

        // Rejected start: zero key.
        start_i = 1'b1; key_i = '0; #1;
        tick();
        start_i = 1'b0; #1;
        chk1("rej_err", err_o, 1'b1);
        chk1("rej_load", core_load_o, 1'b0);
        chk1("rej_busy", busy_o, 1'b0);
        tick();
        chk1("rej_load2", core_load_o, 1'b0);

        start_i = 1'b1; key_i = 80'h1; #1;
        tick();
        start_i = 1'b0; #1;
        chk1("key1_err_clr", err_o, 1'b0);
        chk1("key1_load", core_load_o, 1'b1);

        // Main start: cycle 0.
        start_i = 1'b1; key_i = K_MAIN; iv_i = V_MAIN; #1;
        tick();
        start_i = 1'b0; key_i = '0; iv_i = '0; #1;
        chk1("c1_load", core_load_o, 1'b1);
        chk1("c1_step", core_step_o, 1'b0);
        chkw("c1_core_key", core_key_o, K_MAIN);
        chkw("c1_core_iv", core_iv_o, V_MAIN);
        warm(steps, ncyc, loads);
        chki("warm_steps", steps, 1152);
        chki("warm_cycles", ncyc, 1153);
        chki("warm_loads", loads, 1);
        chk1("c1154_ready", ready_o, 1'b1);
        chk1("c1154_step", core_step_o, 1'b0);
        chk1("c1154_din_ready", din_ready_o, 1'b1);

        // RUN: four accepts, keystream 1,0,1,1 against din 1,1,0,0.
        for (int i = 0; i < 4; i++) begin
            din_valid_i = 1'b1; din_i = dpat[i]; core_z_i = zpat[i]; #1;
            chk1("run_din_ready", din_ready_o, 1'b1);
            chk1("run_step", core_step_o, 1'b1);
            tick();
        end
        din_i = 1'b1; core_z_i = 1'b0; #1;
        tick();

        // Backpressure: pending bit held, no accept, no core step.
        dout_ready_i = 1'b0; din_i = 1'b0; core_z_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("stall_din_ready", din_ready_o, 1'b0);
            chk1("stall_step", core_step_o, 1'b0);
            chk1("stall_valid", dout_valid_o, 1'b1);
            chk1("stall_dout", dout_o, 1'b1);
            tick();
        end

        dout_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din_i = d2[i]; core_z_i = z2[i]; #1;
            tick();
        end
        #1;
        chk1("exh_rekey", rekey_req_o, 1'b1);
        chk1("exh_din_ready", din_ready_o, 1'b0);
        chk1("exh_step", core_step_o, 1'b0);
        chk1("exh_ready", ready_o, 1'b0);
        chk1("exh_drain_valid", dout_valid_o, 1'b1);
        tick();
        chk1("exh_drained", dout_valid_o, 1'b0);
        din_valid_i = 1'b0;

        // Rekey out of EXHAUSTED, then reset in the middle of warm-up.
        start_i = 1'b1; key_i = K_ALT; iv_i = V_MAIN; #1;
        tick();
        start_i = 1'b0; #1;
        chk1("rekey_load", core_load_o, 1'b1);
        chk1("rekey_req_clr", rekey_req_o, 1'b0);
        repeat (501) tick();
        chk1("w500_step", core_step_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk1("arst_step", core_step_o, 1'b0);
        chk1("arst_busy", busy_o, 1'b0);
        chkw("arst_core_key", core_key_o, '0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        tick();
        chk1("arst_idle", busy_o, 1'b0);

        start_i = 1'b1; key_i = K_MAIN; iv_i = V_MAIN; #1;
        tick();
        start_i = 1'b0; #1;
        warm(steps, ncyc, loads);
        chki("rewarm_steps", steps, 1152);
        chk1("rewarm_ready", ready_o, 1'b1);

        // Start in RUN with a pending bit and din_valid: start wins, bit dropped.
        din_valid_i = 1'b1; din_i = 1'b1; core_z_i = 1'b1; #1;
        tick();
        dout_ready_i = 1'b0; start_i = 1'b1; key_i = 80'h5; #1;
        chk1("srun_din_ready", din_ready_o, 1'b0);
        chk1("srun_step", core_step_o, 1'b0);
        tick();
        start_i = 1'b0; din_valid_i = 1'b0; dout_ready_i = 1'b1; #1;
        chk1("srun_load", core_load_o, 1'b1);
        chk1("srun_valid_clr", dout_valid_o, 1'b0);
        chki("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
